alu_result_checker: RTL and testbench
=====================================

Name: alu_result_checker

Overview:
Runtime integrity monitor that sits directly downstream of the 16-bit ALU. It sees the same operand/op stream the ALU receives and consumes the ALU's registered result and flags. It recomputes golden outputs, aligns them to the ALU's latency and compares them. Mismatches are scored in a leaky counter; persistent corruption raises a sticky alarm (payload detection for ALU result-tampering Trojans).

Parameters:
DUT_LATENCY, 1, cycles from the edge that samples operands into the ALU to the edge at which its outputs are compared (legal range 1..4)
SCORE_W, 4, width of the leaky mismatch score
ALARM_THRESH, 3, score value at which ALARM is entered (1..2^SCORE_W-1)
DECAY_LEN, 8, consecutive clean checks required to decrement score by 1 (1..255)

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands below are being presented to the ALU this cycle
A  in  16  operand A, same net as the ALU input
B  in  16  operand B, same net as the ALU input
op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
dut_result  in  16  ALU result
dut_carry  in  1  ALU carry
dut_zero  in  1  ALU zero
dut_overflow  in  1  ALU overflow
dut_negative  in  1  ALU negative
alarm_clr  in  1  clears alarm, score, total count and capture
chk_valid  out  1  a comparison completed this cycle
mismatch  out  1  that comparison failed (qualified by chk_valid)
diff_mask  out  16  dut_result XOR expected result of the last check
flag_err  out  4  {carry,zero,overflow,negative} miscompare bits of the last check
score  out  SCORE_W  leaky mismatch score
total_mismatch  out  16  saturating mismatch count
alarm  out  1  sticky alarm
state  out  2  00 CLEAN, 01 SUSPECT, 10 ALARM
first_fail_a / first_fail_b  out  16 each  operands of the first failing check (see Optional Feature)
first_fail_op  out  2  op of the first failing check

Behaviour:
- Reset (async, rst_n low): all outputs 0, state CLEAN, expected/valid pipeline cleared, decay counter 0. Anything in flight is discarded.
- Golden model, computed when in_valid=1:
  - ADD: t=A+B (17 bit); carry=t[16]; overflow=(A15==B15)&&(r15!=A15).
  - SUB: t=A-B (17 bit); carry=t[16] (borrow); overflow=(A15!=B15)&&(r15!=A15).
  - AND/OR: carry=0, overflow=0.
  - zero=(r==0); negative=r[15].
- Alignment: expected values and valid pass through a DUT_LATENCY-deep register pipeline. in_valid sampled at edge k means dut_* are sampled at edge k+DUT_LATENCY. chk_valid, mismatch, diff_mask and flag_err are registered at that same edge.
- Pipeline accepts one item per cycle, back-to-back, with no stalls.
- chk_valid and mismatch are single-cycle pulses. diff_mask and flag_err hold until the next check.
- mismatch = (diff_mask!=0) || (flag_err!=0).
- total_mismatch increments on each mismatch and saturates at 0xFFFF.
- FSM, evaluated on each edge with chk_valid:
  - CLEAN:
    - mismatch: score=1, go to SUSPECT, or to ALARM if ALARM_THRESH==1.
  - SUSPECT:
    - mismatch: score+1 (saturate), decay counter cleared. Go to ALARM when score reaches ALARM_THRESH.
    - clean check: decay counter+1. At DECAY_LEN, score-1 and decay counter cleared; score reaching 0 goes to CLEAN.
  - ALARM:
    - alarm=1, no decay. Mismatches still increment score (saturate) and total.
    - Leaves only via alarm_clr or reset.
- alarm_clr: synchronous. Score, total, decay counter and capture go to 0, alarm goes to 0, state to CLEAN.
  - If a mismatch is compared on the same edge, the clear applies first and then the mismatch is counted: score=1, total=1, SUSPECT.
  - The in-flight pipeline is not flushed.
- A check with in_valid never asserted produces no chk_valid. Idle cycles do not advance the decay counter.

Optional Feature:
FAIL_CAPTURE_EN:
- Defined:
  - A, B and op travel with the expected pipeline.
  - On the first mismatch since reset or alarm_clr, they are latched into first_fail_a/b/op; later mismatches do not overwrite them.
- Undefined:
  - first_fail_* are tied to 0 and no capture storage exists.

Test Plan:
1. Reset: hold rst_n=0 with in_valid=1 toggling -> all outputs 0, state=00. Release -> first chk_valid only DUT_LATENCY edges after the first in_valid sampled post-reset.
2. ADD A=0x1234 B=0x0001, dut_result=0x1235, flags c0 z0 v0 n0 -> chk_valid=1, mismatch=0, diff_mask=0, score=0.
3. ADD A=0xFFFF B=0xFFFF, dut_result=0xFFFF (expected 0xFFFE, c1 z0 v0 n1) -> mismatch=1, diff_mask=0x0001, flag_err=0, score=1, state=SUSPECT. With FAIL_CAPTURE_EN: first_fail_a=0xFFFF, first_fail_op=00.
4. Three back-to-back corrupted checks (ALARM_THRESH=3) -> alarm=1 on the third. 20 clean checks -> alarm stays 1. alarm_clr plus a simultaneous mismatch -> alarm=0, score=1, total_mismatch=1, state=SUSPECT.
5. SUB A=0x0000 B=0x0001 correct (0xFFFF, c1 v0 n1 z0) -> no mismatch. Then one mismatch followed by 8 clean checks -> score 1->0, state CLEAN. Idle gaps between those checks do not alter the outcome.
6. AND op with dut_carry=1 -> flag_err=4'b1000, mismatch=1, diff_mask=0. Assert rst_n low mid-stream with 3 checks in flight -> none of them produce chk_valid after release.

Source files
------------

// File: rtl/alu_result_checker.sv
// alu_result_checker: runtime integrity monitor for the 16-bit ALU.
// Recomputes golden result/flags, aligns them to DUT_LATENCY and compares.
// Mismatches feed a leaky score; persistent corruption raises a sticky alarm.
// Optional macro FAIL_CAPTURE_EN: latch operands/op of the first failing check.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid, A, B, op  operand stream presented to the ALU
//   dut_*               ALU registered result and flags
//   alarm_clr           sync clear of alarm, score, total and capture
//   chk_valid, mismatch single-cycle check pulse and its outcome
//   diff_mask, flag_err result/flag miscompare bits of the last check
//   score, total_mismatch, alarm, state  scoring status
//   first_fail_a/b/op   operands of the first failing check (or 0)
module alu_result_checker #(
    parameter int DUT_LATENCY  = 1,
    parameter int SCORE_W      = 4,
    parameter int ALARM_THRESH = 3,
    parameter int DECAY_LEN    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [15:0]        A,
    input  logic [15:0]        B,
    input  logic [1:0]         op,
    input  logic [15:0]        dut_result,
    input  logic               dut_carry,
    input  logic               dut_zero,
    input  logic               dut_overflow,
    input  logic               dut_negative,
    input  logic               alarm_clr,
    output logic               chk_valid,
    output logic               mismatch,
    output logic [15:0]        diff_mask,
    output logic [3:0]         flag_err,
    output logic [SCORE_W-1:0] score,
    output logic [15:0]        total_mismatch,
    output logic               alarm,
    output logic [1:0]         state,
    output logic [15:0]        first_fail_a,
    output logic [15:0]        first_fail_b,
    output logic [1:0]         first_fail_op
);

    typedef enum logic [1:0] {
        ST_CLEAN   = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_ALARM   = 2'b10
    } st_e;

    localparam int LAST = DUT_LATENCY - 1;
    localparam logic [SCORE_W-1:0] S_ONE = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] S_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] S_TH  = SCORE_W'(ALARM_THRESH);
    localparam logic [7:0]         D_END = 8'(DECAY_LEN - 1);
    localparam logic               TH_ONE = (ALARM_THRESH == 1);

    // Golden model
    logic [16:0] t_w;
    logic [15:0] g_res;
    logic        g_c;
    logic        g_v;
    logic [19:0] g_exp;

    always_comb begin
        t_w = 17'd0;
        g_c = 1'b0;
        g_v = 1'b0;
        unique case (op)
            2'b00: begin
                t_w = {1'b0, A} + {1'b0, B};
                g_c = t_w[16];
                g_v = (A[15] == B[15]) && (t_w[15] != A[15]);
            end
            2'b01: begin
                t_w = {1'b0, A} - {1'b0, B};
                g_c = t_w[16];
                g_v = (A[15] != B[15]) && (t_w[15] != A[15]);
            end
            2'b10:   t_w = {1'b0, A & B};
            default: t_w = {1'b0, A | B};
        endcase
    end

    assign g_res = t_w[15:0];
    assign g_exp = {g_res, g_c, (g_res == 16'd0), g_v, g_res[15]};

    // Alignment pipeline: {result, c, z, v, n} and valid
    logic [19:0]            exp_q [DUT_LATENCY];
    logic [DUT_LATENCY-1:0] vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DUT_LATENCY; i++) exp_q[i] <= '0;
        end else begin
            vld_q[0] <= in_valid;
            exp_q[0] <= g_exp;
            for (int i = 1; i < DUT_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
            end
        end
    end

    // Compare stage
    logic        cmp_v;
    logic [15:0] dm_w;
    logic [3:0]  fe_w;
    logic        mm_w;

    assign cmp_v = vld_q[LAST];
    assign dm_w  = dut_result ^ exp_q[LAST][19:4];
    assign fe_w  = {dut_carry, dut_zero, dut_overflow, dut_negative}
                 ^ exp_q[LAST][3:0];
    assign mm_w  = cmp_v && ((dm_w != 16'd0) || (fe_w != 4'd0));

    logic        chk_q;
    logic        mm_q;
    logic [15:0] dm_q;
    logic [3:0]  fe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= 1'b0;
            mm_q  <= 1'b0;
            dm_q  <= '0;
            fe_q  <= '0;
        end else begin
            chk_q <= cmp_v;
            mm_q  <= mm_w;
            if (cmp_v) begin
                dm_q <= dm_w;
                fe_q <= fe_w;
            end
        end
    end

    // Scoring FSM; alarm_clr is folded in first so a coincident
    // mismatch is counted against the cleared state.
    st_e                state_q;
    logic [SCORE_W-1:0] score_q;
    logic [7:0]         dec_q;
    logic [15:0]        tot_q;
    logic               alarm_q;

    st_e                st_c;
    logic [SCORE_W-1:0] score_c;
    logic [SCORE_W-1:0] score_inc;
    logic [7:0]         dec_c;
    logic [15:0]        tot_c;

    always_comb begin
        st_c      = alarm_clr ? ST_CLEAN : state_q;
        score_c   = alarm_clr ? '0 : score_q;
        dec_c     = alarm_clr ? '0 : dec_q;
        tot_c     = alarm_clr ? '0 : tot_q;
        score_inc = (score_c == S_MAX) ? score_c : score_c + S_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAN;
            score_q <= '0;
            dec_q   <= '0;
            tot_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= st_c;
            score_q <= score_c;
            dec_q   <= dec_c;
            tot_q   <= tot_c;
            alarm_q <= (st_c == ST_ALARM);
            if (mm_w && (tot_c != 16'hFFFF)) tot_q <= tot_c + 16'd1;
            if (cmp_v) begin
                unique case (st_c)
                    ST_CLEAN: begin
                        if (mm_w) begin
                            score_q <= S_ONE;
                            dec_q   <= '0;
                            if (TH_ONE) begin
                                state_q <= ST_ALARM;
                                alarm_q <= 1'b1;
                            end else begin
                                state_q <= ST_SUSPECT;
                            end
                        end
                    end
                    ST_SUSPECT: begin
                        if (mm_w) begin
                            score_q <= score_inc;
                            dec_q   <= '0;
                            if (score_inc >= S_TH) begin
                                state_q <= ST_ALARM;
                                alarm_q <= 1'b1;
                            end
                        end else if (dec_c == D_END) begin
                            dec_q   <= '0;
                            score_q <= score_c - S_ONE;
                            if (score_c == S_ONE) state_q <= ST_CLEAN;
                        end else begin
                            dec_q <= dec_c + 8'd1;
                        end
                    end
                    default: begin
                        if (mm_w) score_q <= score_inc;
                    end
                endcase
            end
        end
    end

`ifdef FAIL_CAPTURE_EN
    // Operands travel alongside the expected values
    logic [33:0] cap_q [DUT_LATENCY];
    logic [33:0] ff_q;
    logic        seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DUT_LATENCY; i++) cap_q[i] <= '0;
        end else begin
            cap_q[0] <= {A, B, op};
            for (int i = 1; i < DUT_LATENCY; i++) cap_q[i] <= cap_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q   <= '0;
            seen_q <= 1'b0;
        end else begin
            if (alarm_clr) begin
                ff_q   <= '0;
                seen_q <= 1'b0;
            end
            if (mm_w && (alarm_clr || !seen_q)) begin
                ff_q   <= cap_q[LAST];
                seen_q <= 1'b1;
            end
        end
    end

    assign first_fail_a  = ff_q[33:18];
    assign first_fail_b  = ff_q[17:2];
    assign first_fail_op = ff_q[1:0];
`else
    assign first_fail_a  = '0;
    assign first_fail_b  = '0;
    assign first_fail_op = '0;
`endif

    assign chk_valid      = chk_q;
    assign mismatch       = mm_q;
    assign diff_mask      = dm_q;
    assign flag_err       = fe_q;
    assign score          = score_q;
    assign total_mismatch = tot_q;
    assign alarm          = alarm_q;
    assign state          = state_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed + random bench for alu_result_checker.
// The bench plays the ALU (with injectable corruption) and models scoring.
module tb_alu_result_checker;

    localparam int LAT  = 3;
    localparam int SW   = 4;
    localparam int TH   = 3;
    localparam int DL   = 8;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [15:0]   A = '0;
    logic [15:0]   B = '0;
    logic [1:0]    op = '0;
    logic [15:0]   dut_result = '0;
    logic          dut_carry = 1'b0;
    logic          dut_zero = 1'b0;
    logic          dut_overflow = 1'b0;
    logic          dut_negative = 1'b0;
    logic          alarm_clr = 1'b0;
    logic          chk_valid;
    logic          mismatch;
    logic [15:0]   diff_mask;
    logic [3:0]    flag_err;
    logic [SW-1:0] score;
    logic [15:0]   total_mismatch;
    logic          alarm;
    logic [1:0]    state;
    logic [15:0]   first_fail_a;
    logic [15:0]   first_fail_b;
    logic [1:0]    first_fail_op;

    alu_result_checker #(
        .DUT_LATENCY (LAT),
        .SCORE_W     (SW),
        .ALARM_THRESH(TH),
        .DECAY_LEN   (DL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .A             (A),
        .B             (B),
        .op            (op),
        .dut_result    (dut_result),
        .dut_carry     (dut_carry),
        .dut_zero      (dut_zero),
        .dut_overflow  (dut_overflow),
        .dut_negative  (dut_negative),
        .alarm_clr     (alarm_clr),
        .chk_valid     (chk_valid),
        .mismatch      (mismatch),
        .diff_mask     (diff_mask),
        .flag_err      (flag_err),
        .score         (score),
        .total_mismatch(total_mismatch),
        .alarm         (alarm),
        .state         (state),
        .first_fail_a  (first_fail_a),
        .first_fail_b  (first_fail_b),
        .first_fail_op (first_fail_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] xr;
        logic [3:0]  xf;
        logic        clr;
    } item_t;

    item_t pend[$];

    int checks = 0;
    int errors = 0;

    int          m_score, m_total, m_dec, m_st;
    logic [15:0] m_diff;
    logic [3:0]  m_fe;
    logic        m_chk, m_mm, m_seen;
    logic [15:0] m_ffa, m_ffb;
    logic [1:0]  m_ffop;

    // {result, carry, zero, overflow, negative} from plain integer arithmetic
    function automatic logic [19:0] gold(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [1:0] o);
        int ua, ub, sa, sb, u, s;
        logic [15:0] r;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        u = 0;
        s = 0;
        c = 1'b0;
        v = 1'b0;
        case (o)
            2'd0: begin
                u = ua + ub;
                s = sa + sb;
                c = (u > 65535);
                v = (s > 32767) || (s < -32768);
            end
            2'd1: begin
                u = ua - ub;
                s = sa - sb;
                c = (ua < ub);
                v = (s > 32767) || (s < -32768);
            end
            2'd2: u = int'(a & b);
            default: u = int'(a | b);
        endcase
        r = u[15:0];
        return {r, c, (r == 16'd0), v, r[15]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_score = 0;
        m_total = 0;
        m_dec = 0;
        m_st = 0;
        m_diff = '0;
        m_fe = '0;
        m_chk = 1'b0;
        m_mm = 1'b0;
        m_seen = 1'b0;
        m_ffa = '0;
        m_ffb = '0;
        m_ffop = '0;
        pend.delete();
        repeat (LAT) pend.push_back('0);
    endtask

    task automatic model_edge(input item_t f);
        if (f.clr) begin
            m_score = 0;
            m_total = 0;
            m_dec = 0;
            m_st = 0;
            m_seen = 1'b0;
            m_ffa = '0;
            m_ffb = '0;
            m_ffop = '0;
        end
        m_chk = f.v;
        m_mm = f.v && ((f.xr != 0) || (f.xf != 0));
        if (!f.v) return;
        m_diff = f.xr;
        m_fe = f.xf;
        if (m_mm) begin
            if (m_total < 65535) m_total++;
            if (!m_seen) begin
                m_seen = 1'b1;
                m_ffa = f.a;
                m_ffb = f.b;
                m_ffop = f.op;
            end
            if (m_st == 0) begin
                m_score = 1;
                m_st = (TH == 1) ? 2 : 1;
            end else begin
                if (m_score < SMAX) m_score++;
                m_dec = 0;
                if (m_score >= TH) m_st = 2;
            end
        end else if (m_st == 1) begin
            m_dec++;
            if (m_dec == DL) begin
                m_dec = 0;
                m_score--;
                if (m_score == 0) m_st = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("chk_valid", chk_valid, m_chk);
        chk("mismatch", mismatch, m_mm);
        chk("diff_mask", diff_mask, m_diff);
        chk("flag_err", flag_err, m_fe);
        chk("score", score, m_score);
        chk("state", state, m_st);
        chk("alarm", alarm, (m_st == 2));
        chk("total", total_mismatch, m_total);
`ifdef FAIL_CAPTURE_EN
        chk("ff_a", first_fail_a, m_ffa);
        chk("ff_b", first_fail_b, m_ffb);
        chk("ff_op", first_fail_op, m_ffop);
`else
        chk("ff_a", first_fail_a, 0);
        chk("ff_b", first_fail_b, 0);
        chk("ff_op", first_fail_op, 0);
`endif
    endtask

    task automatic step(input logic v, input logic [15:0] a,
                        input logic [15:0] b, input logic [1:0] o,
                        input logic [15:0] xr, input logic [3:0] xf,
                        input logic clr);
        item_t f;
        item_t n;
        logic [19:0] g;
        @(negedge clk);
        f = pend.pop_front();
        g = gold(f.a, f.b, f.op);
        if (f.v) begin
            dut_result = g[19:4] ^ f.xr;
            {dut_carry, dut_zero, dut_overflow, dut_negative} = g[3:0] ^ f.xf;
        end else begin
            dut_result = 16'($urandom);
            {dut_carry, dut_zero, dut_overflow, dut_negative} = 4'($urandom);
        end
        alarm_clr = f.clr;
        in_valid = v;
        A = v ? a : 16'($urandom);
        B = v ? b : 16'($urandom);
        op = v ? o : 2'($urandom);
        n.v = v;
        n.a = a;
        n.b = b;
        n.op = o;
        n.xr = xr;
        n.xf = xf;
        n.clr = clr;
        pend.push_back(n);
        @(posedge clk);
        model_edge(f);
        #1 check_all();
    endtask

    task automatic idle();
        step(1'b0, 16'd0, 16'd0, 2'd0, 16'd0, 4'd0, 1'b0);
    endtask

    task automatic flush();
        repeat (LAT) idle();
    endtask

    task automatic clean_rand();
        step(1'b1, 16'($urandom), 16'($urandom), 2'($urandom),
             16'd0, 4'd0, 1'b0);
    endtask

    task automatic bad_rand();
        step(1'b1, 16'($urandom), 16'($urandom), 2'($urandom),
             16'h0100, 4'd0, 1'b0);
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        alarm_clr = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (ncyc) begin
            @(negedge clk);
            in_valid = ~in_valid;
            A = 16'($urandom);
            B = 16'($urandom);
            @(posedge clk);
            #1 check_all();
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset(4);

        // First check only LAT edges after first post-reset in_valid
        step(1'b1, 16'h1234, 16'h0001, 2'd0, 16'd0, 4'd0, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            idle();
            chk("latency", chk_valid, (k == LAT));
        end
        chk("add_mm", mismatch, 0);
        chk("add_dm", diff_mask, 0);
        chk("add_sc", score, 0);

        // ADD FFFF+FFFF reported as FFFF instead of FFFE
        step(1'b1, 16'hFFFF, 16'hFFFF, 2'd0, 16'h0001, 4'd0, 1'b0);
        flush();
        chk("ovf_mm", mismatch, 1);
        chk("ovf_dm", diff_mask, 16'h0001);
        chk("ovf_fe", flag_err, 0);
        chk("ovf_sc", score, 1);
        chk("ovf_st", state, 1);
`ifdef FAIL_CAPTURE_EN
        chk("ovf_ffa", first_fail_a, 16'hFFFF);
        chk("ovf_ffop", first_fail_op, 0);
`endif

        // Decay back to CLEAN, then three back-to-back failures
        repeat (DL) clean_rand();
        flush();
        chk("decay_st", state, 0);
        repeat (3) bad_rand();
        flush();
        chk("alarm_on", alarm, 1);
        repeat (20) clean_rand();
        flush();
        chk("alarm_sticky", alarm, 1);
        step(1'b1, 16'h00F0, 16'h0F00, 2'd3, 16'h8000, 4'd0, 1'b1);
        flush();
        chk("clr_alarm", alarm, 0);
        chk("clr_score", score, 1);
        chk("clr_total", total_mismatch, 1);
        chk("clr_state", state, 1);

        // SUB borrow case, then single failure decays with idle gaps
        repeat (DL) clean_rand();
        step(1'b1, 16'h0000, 16'h0001, 2'd1, 16'd0, 4'd0, 1'b0);
        flush();
        chk("sub_mm", mismatch, 0);
        chk("sub_st", state, 0);
        bad_rand();
        repeat (DL) begin
            repeat ($urandom_range(0, 2)) idle();
            clean_rand();
        end
        flush();
        chk("gap_sc", score, 0);
        chk("gap_st", state, 0);

        // AND with bogus carry
        step(1'b1, 16'hF0F0, 16'h0FF0, 2'd2, 16'd0, 4'b1000, 1'b0);
        flush();
        chk("and_fe", flag_err, 4'b1000);
        chk("and_mm", mismatch, 1);
        chk("and_dm", diff_mask, 0);

        // Reset with LAT checks in flight
        repeat (LAT) bad_rand();
        do_reset(2);
        for (int k = 0; k < LAT + 2; k++) begin
            idle();
            chk("flush_rst", chk_valid, 0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        v;
            logic [15:0] a, b, xr;
            logic [3:0]  xf;
            v  = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
            xr = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'd0;
            xf = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            step(v, a, b, 2'($urandom), xr, xf, ($urandom_range(0, 49) == 0));
        end
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
